// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: total width, coin values,
// one-hot coin bit positions and FSM state encoding.
package change_dispenser_pkg;

  localparam int unsigned kTotalBits = 31;

  localparam int unsigned kCoinVal0 = 100;
  localparam int unsigned kCoinVal1 = 500;
  localparam int unsigned kCoinVal2 = 1000;

  localparam int unsigned kCoinIdx0 = 0;
  localparam int unsigned kCoinIdx1 = 1;
  localparam int unsigned kCoinIdx2 = 2;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StLoad     = 2'd1,
    StDispense = 2'd2,
    StDone     = 2'd3
  } state_e;

endpackage

// File: rtl/change_dispenser_coin_select.sv
// Combinational largest-fit coin picker: remaining amount -> one-hot coin
// select and its value. All-zero when nothing fits.
module change_dispenser_coin_select
  import change_dispenser_pkg::*;
#(
  parameter int unsigned TOTAL_BITS = kTotalBits,
  parameter int unsigned COIN_VAL0  = kCoinVal0,
  parameter int unsigned COIN_VAL1  = kCoinVal1,
  parameter int unsigned COIN_VAL2  = kCoinVal2
) (
  input  logic [TOTAL_BITS-1:0] remaining,
  output logic [2:0]            coin,
  output logic [TOTAL_BITS-1:0] coin_val
);

  always_comb begin
    coin     = '0;
    coin_val = '0;
    if (remaining >= TOTAL_BITS'(COIN_VAL2)) begin
      coin[kCoinIdx2] = 1'b1;
      coin_val        = TOTAL_BITS'(COIN_VAL2);
    end else if (remaining >= TOTAL_BITS'(COIN_VAL1)) begin
      coin[kCoinIdx1] = 1'b1;
      coin_val        = TOTAL_BITS'(COIN_VAL1);
    end else if (remaining >= TOTAL_BITS'(COIN_VAL0)) begin
      coin[kCoinIdx0] = 1'b1;
      coin_val        = TOTAL_BITS'(COIN_VAL0);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Latches the running total on a return trigger and pays it out one coin at a
// time (largest first) over a valid/ready handshake, then pulses done.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned TOTAL_BITS = kTotalBits,
  parameter int unsigned COIN_VAL0  = kCoinVal0,
  parameter int unsigned COIN_VAL1  = kCoinVal1,
  parameter int unsigned COIN_VAL2  = kCoinVal2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_trigger_return,
  input  logic [TOTAL_BITS-1:0] i_total,
  input  logic                  i_coin_ready,
  output logic                  o_coin_valid,
  output logic [2:0]            o_return_coin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [TOTAL_BITS-1:0] o_remaining,
  output logic [TOTAL_BITS-1:0] o_residual
);

  state_e                  state_q, state_d;
  logic [TOTAL_BITS-1:0]   remaining_q, remaining_d;
  logic [TOTAL_BITS-1:0]   residual_q, residual_d;
  logic [2:0]              coin_q, coin_d;
  logic [TOTAL_BITS-1:0]   coin_val_q, coin_val_d;
  logic [2:0]              sel_coin;
  logic [TOTAL_BITS-1:0]   sel_val;
  logic                    fire;

  // Selection looks at next-state remaining so the coin register is already
  // correct on the cycle DISPENSE is entered or after each fire.
  change_dispenser_coin_select #(
    .TOTAL_BITS (TOTAL_BITS),
    .COIN_VAL0  (COIN_VAL0),
    .COIN_VAL1  (COIN_VAL1),
    .COIN_VAL2  (COIN_VAL2)
  ) u_coin_select (
    .remaining (remaining_d),
    .coin      (sel_coin),
    .coin_val  (sel_val)
  );

  assign fire = (state_q == StDispense) && i_coin_ready;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    residual_d  = residual_q;
    unique case (state_q)
      StIdle: begin
        if (i_trigger_return) begin
          remaining_d = i_total;
          residual_d  = '0;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        state_d = (remaining_q >= TOTAL_BITS'(COIN_VAL0)) ? StDispense : StDone;
      end
      StDispense: begin
        if (fire) begin
          remaining_d = remaining_q - coin_val_q;
          if (remaining_d < TOTAL_BITS'(COIN_VAL0)) state_d = StDone;
        end
      end
      StDone: begin
        residual_d  = remaining_q;
        remaining_d = '0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
    coin_d     = (state_d == StDispense) ? sel_coin : '0;
    coin_val_d = (state_d == StDispense) ? sel_val  : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      residual_q  <= '0;
      coin_q      <= '0;
      coin_val_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      residual_q  <= residual_d;
      coin_q      <= coin_d;
      coin_val_q  <= coin_val_d;
    end
  end

  assign o_coin_valid  = (state_q == StDispense);
  assign o_return_coin = coin_q;
  assign o_busy        = (state_q != StIdle);
  assign o_done        = (state_q == StDone);
  assign o_remaining   = remaining_q;
  assign o_residual    = residual_q;

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    fire |-> (remaining_q >= coin_val_q));

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus random
// totals and ready patterns against a divide/modulo payout model.
module tb_change_dispenser;

  localparam int unsigned TB = 31;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_trigger_return;
  logic [TB-1:0] i_total;
  logic          i_coin_ready;
  logic          o_coin_valid;
  logic [2:0]    o_return_coin;
  logic          o_busy;
  logic          o_done;
  logic [TB-1:0] o_remaining;
  logic [TB-1:0] o_residual;

  int errors = 0;
  int checks = 0;

  change_dispenser dut (
    .clk              (clk),
    .reset            (reset),
    .i_trigger_return (i_trigger_return),
    .i_total          (i_total),
    .i_coin_ready     (i_coin_ready),
    .o_coin_valid     (o_coin_valid),
    .o_return_coin    (o_return_coin),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_remaining      (o_remaining),
    .o_residual       (o_residual)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, {31'd0, o_coin_valid}, 0);
    check({tag, "_coin"}, {29'd0, o_return_coin}, 0);
    check({tag, "_busy"}, {31'd0, o_busy}, 0);
    check({tag, "_done"}, {31'd0, o_done}, 0);
    check({tag, "_remaining"}, {1'b0, o_remaining}, 0);
    check({tag, "_residual"}, {1'b0, o_residual}, 0);
  endtask

  // mode 0: ready always 1; mode 1: random ready; mode 2: stall first 5 valid cycles
  task automatic payout(input string tag, input int unsigned total, input int mode,
                        input bit retrig);
    int unsigned exp_q[$];
    int unsigned model_rem;
    int n1000, n500, n100, n_exp;
    int cyc, first_valid, done_cyc, last_fire, fires, stall, done_cnt;
    logic rdy;

    // Greedy count for 100/500/1000 directly from place values.
    n1000 = int'(total / 1000);
    n500  = int'((total % 1000) / 500);
    n100  = int'((total % 500) / 100);
    for (int i = 0; i < n1000; i++) exp_q.push_back(4);
    for (int i = 0; i < n500; i++)  exp_q.push_back(2);
    for (int i = 0; i < n100; i++)  exp_q.push_back(1);
    n_exp = exp_q.size();
    model_rem = total;

    @(negedge clk);
    i_trigger_return = 1'b1;
    i_total          = TB'(total);
    i_coin_ready     = 1'b0;
    @(negedge clk);
    i_trigger_return = 1'b0;
    cyc = 1; first_valid = -1; done_cyc = -1; last_fire = -1;
    fires = 0; stall = 0; done_cnt = 0;

    while (cyc < 3000) begin
      if (done_cyc >= 0) break;
      check({tag, "_busy"}, {31'd0, o_busy}, 1);
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        i_trigger_return = 1'b0;
      end else begin
        check({tag, "_remaining"}, {1'b0, o_remaining}, model_rem);
      end
      if (o_coin_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (exp_q.size() > 0) check({tag, "_coin"}, {29'd0, o_return_coin}, exp_q[0]);
        else check({tag, "_extra_coin"}, {31'd0, o_coin_valid}, 0);
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = 1'($urandom_range(0, 1));
          default: begin rdy = (stall >= 5); stall++; end
        endcase
        if (rdy && exp_q.size() > 0) begin
          model_rem = model_rem - ((exp_q[0] == 4) ? 1000 : (exp_q[0] == 2) ? 500 : 100);
          void'(exp_q.pop_front());
        end
        if (rdy) begin
          fires++;
          last_fire = cyc;
        end
      end else begin
        check({tag, "_coin_idle"}, {29'd0, o_return_coin}, 0);
        rdy = 1'($urandom_range(0, 1));
      end
      i_coin_ready = rdy;
      if (retrig && !o_done) begin
        i_trigger_return = (fires == 1);
        i_total          = TB'(500);
      end
      @(negedge clk);
      cyc++;
    end
    i_trigger_return = 1'b0;
    i_coin_ready     = 1'b0;

    check({tag, "_completed"}, {31'd0, done_cyc >= 0}, 1);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_fires"}, fires, n_exp);
    check({tag, "_residual"}, {1'b0, o_residual}, total % 100);
    check({tag, "_remaining_end"}, {1'b0, o_remaining}, 0);
    check({tag, "_busy_end"}, {31'd0, o_busy}, 0);
    check({tag, "_done_end"}, {31'd0, o_done}, 0);
    if (n_exp > 0) begin
      check({tag, "_first_valid_lat"}, first_valid, 2);
      check({tag, "_done_after_last"}, done_cyc, last_fire + 1);
    end else begin
      check({tag, "_no_valid"}, {31'd0, first_valid < 0}, 1);
      check({tag, "_done_lat"}, done_cyc, 2);
    end
  endtask

  initial begin
    reset            = 1'b1;
    i_trigger_return = 1'b0;
    i_total          = '0;
    i_coin_ready     = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;

    payout("basic1600", 1600, 0, 1'b0);
    payout("resid750", 750, 0, 1'b0);
    payout("stall1100", 1100, 2, 1'b0);
    payout("zero", 0, 0, 1'b0);
    payout("sub99", 99, 0, 1'b0);
    payout("retrig2000", 2000, 0, 1'b1);

    // Reset after the first coin has been accepted.
    @(negedge clk);
    i_trigger_return = 1'b1;
    i_total          = TB'(3000);
    @(negedge clk);
    i_trigger_return = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", {31'd0, o_coin_valid}, 1);
    check("rst_mid_coin", {29'd0, o_return_coin}, 4);
    i_coin_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_rem", {1'b0, o_remaining}, 2000);
    reset        = 1'b1;
    i_coin_ready = 1'b0;
    @(negedge clk);
    check_idle_zero("rst_mid");
    reset = 1'b0;

    // Trigger and reset together: reset wins.
    i_trigger_return = 1'b1;
    i_total          = TB'(500);
    reset            = 1'b1;
    @(negedge clk);
    reset            = 1'b0;
    i_trigger_return = 1'b0;
    @(negedge clk);
    check("trig_rst_busy", {31'd0, o_busy}, 0);
    check("trig_rst_rem", {1'b0, o_remaining}, 0);

    payout("after_rst100", 100, 0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      payout("random", $urandom_range(0, 9999), 1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
